// File: rtl/wb_arb_pkg.sv
// Shared types for the Wishbone arbiter: FSM state encoding and watchdog width.
package wb_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    // Watchdog counter width; TIMEOUT must fit in it.
    localparam int TO_CNT_W = 16;

endpackage

// File: rtl/wb_arbiter_n_rr_picker.sv
// Combinational round-robin priority encoder: searches upward from i_ptr+1 (mod NUM_M)
// and returns the first requester as a one-hot vector.
module rr_picker #(
    parameter int NUM_M = 2,
    parameter int PW    = (NUM_M > 1) ? $clog2(NUM_M) : 1
) (
    input  logic [NUM_M-1:0] i_req,
    input  logic [PW-1:0]    i_ptr,
    output logic [NUM_M-1:0] o_gnt
);

    // ptr <= NUM_M-1 and off <= NUM_M, so the sum always fits in PW+1 bits.
    localparam logic [PW:0] LP_NM = (PW+1)'(NUM_M);

    always_comb begin
        logic          found;
        logic [PW:0]   sum;
        logic [PW-1:0] idx;
        o_gnt = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int off = 1; off <= NUM_M; off++) begin
            sum = {1'b0, i_ptr} + (PW+1)'(off);
            if (sum >= LP_NM) begin
                sum = sum - LP_NM;
            end
            idx = sum[PW-1:0];
            if (!found && i_req[idx]) begin
                o_gnt[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter_n.sv
// N-master Wishbone B3 classic arbiter with round-robin fairness and grant visibility.
// Optional bus watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arbiter_n
    import wb_arb_pkg::*;
#(
    parameter int NUM_M   = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                    CLK_I,
    input  logic                    RST_I,
    input  logic [NUM_M-1:0]        M_CYC_I,
    input  logic [NUM_M-1:0]        M_STB_I,
    input  logic [NUM_M-1:0]        M_WE_I,
    input  logic [NUM_M*AW-1:0]     M_ADR_I,
    input  logic [NUM_M*DW-1:0]     M_DAT_I,
    input  logic [NUM_M*DW/8-1:0]   M_SEL_I,
    output logic [DW-1:0]           M_DAT_O,
    output logic [NUM_M-1:0]        M_ACK_O,
    output logic [NUM_M-1:0]        M_ERR_O,
    output logic                    S_CYC_O,
    output logic                    S_STB_O,
    output logic                    S_WE_O,
    output logic [AW-1:0]           S_ADR_O,
    output logic [DW-1:0]           S_DAT_O,
    output logic [DW/8-1:0]         S_SEL_O,
    input  logic [DW-1:0]           S_DAT_I,
    input  logic                    S_ACK_I,
    input  logic                    S_ERR_I,
    output logic [NUM_M-1:0]        GRANT_O
);

    localparam int PW = $clog2(NUM_M);
    localparam int SW = DW / 8;

    if ((NUM_M < 2) || (NUM_M > 8)) begin : g_chk_num_m
        $error("wb_arbiter_n: NUM_M must be in 2..8");
    end
    if ((DW % 8) != 0) begin : g_chk_dw
        $error("wb_arbiter_n: DW must be a multiple of 8");
    end
    if ((TIMEOUT < 1) || (TIMEOUT >= (1 << TO_CNT_W))) begin : g_chk_timeout
        $error("wb_arbiter_n: TIMEOUT must fit the watchdog counter");
    end

    arb_state_e       r_state, w_state_nxt;
    logic [NUM_M-1:0] r_grant, w_grant_nxt;
    logic [PW-1:0]    r_ptr, w_ptr_nxt;
    logic [PW-1:0]    r_gidx, w_gidx_nxt;
    logic [NUM_M-1:0] w_pick;
    logic [PW-1:0]    w_pick_idx;
    logic             w_busy;
    logic             w_own_cyc;

    logic             w_cyc_mux, w_stb_mux, w_we_mux;
    logic [AW-1:0]    w_adr_mux;
    logic [DW-1:0]    w_dat_mux;
    logic [SW-1:0]    w_sel_mux;

    rr_picker #(
        .NUM_M (NUM_M),
        .PW    (PW)
    ) u_pick (
        .i_req (M_CYC_I),
        .i_ptr (r_ptr),
        .o_gnt (w_pick)
    );

    always_comb begin
        w_pick_idx = '0;
        for (int k = 0; k < NUM_M; k++) begin
            if (w_pick[k]) begin
                w_pick_idx = PW'(k);
            end
        end
    end

    assign w_busy    = (r_state == BUSY);
    assign w_own_cyc = |(M_CYC_I & r_grant);

    // Grant is all-zero in IDLE, so the mux naturally drives the slave port to 0.
    always_comb begin
        w_cyc_mux = 1'b0;
        w_stb_mux = 1'b0;
        w_we_mux  = 1'b0;
        w_adr_mux = '0;
        w_dat_mux = '0;
        w_sel_mux = '0;
        for (int k = 0; k < NUM_M; k++) begin
            if (r_grant[k]) begin
                w_cyc_mux = M_CYC_I[k];
                w_stb_mux = M_STB_I[k];
                w_we_mux  = M_WE_I[k];
                w_adr_mux = M_ADR_I[k*AW +: AW];
                w_dat_mux = M_DAT_I[k*DW +: DW];
                w_sel_mux = M_SEL_I[k*SW +: SW];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_ptr_nxt   = r_ptr;
        w_gidx_nxt  = r_gidx;
        case (r_state)
            IDLE: begin
                if (|M_CYC_I) begin
                    w_state_nxt = BUSY;
                    w_grant_nxt = w_pick;
                    w_gidx_nxt  = w_pick_idx;
                end
            end
            BUSY: begin
                // Ownership lasts the whole CYC; the pointer only moves on release.
                if (!w_own_cyc) begin
                    w_state_nxt = IDLE;
                    w_grant_nxt = '0;
                    w_ptr_nxt   = r_gidx;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_ptr   <= PW'(NUM_M - 1);
            r_gidx  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_ptr   <= w_ptr_nxt;
            r_gidx  <= w_gidx_nxt;
        end
    end

    assign S_CYC_O = w_cyc_mux;
    assign S_WE_O  = w_we_mux;
    assign S_ADR_O = w_adr_mux;
    assign S_DAT_O = w_dat_mux;
    assign S_SEL_O = w_sel_mux;
    assign GRANT_O = r_grant;
    assign M_DAT_O = w_busy ? S_DAT_I : '0;
    assign M_ACK_O = w_busy ? (r_grant & {NUM_M{S_ACK_I}}) : '0;

`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [TO_CNT_W-1:0] LP_TO = TO_CNT_W'(TIMEOUT);

    logic [TO_CNT_W-1:0] r_to_cnt;
    logic                w_to_hit;

    assign w_to_hit = w_busy && (r_to_cnt == LP_TO);

    // Held at zero while IDLE so every new grant starts from a clean count.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_to_cnt <= '0;
        end else if (!w_busy || w_to_hit || S_ACK_I || S_ERR_I) begin
            r_to_cnt <= '0;
        end else if (w_stb_mux) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    assign S_STB_O = w_stb_mux & ~w_to_hit;
    assign M_ERR_O = w_busy ? (r_grant & {NUM_M{S_ERR_I | w_to_hit}}) : '0;
`else
    assign S_STB_O = w_stb_mux;
    assign M_ERR_O = w_busy ? (r_grant & {NUM_M{S_ERR_I}}) : '0;
`endif

endmodule

// File: tb/tb_wb_arbiter_n.sv
// Self-checking bench for wb_arbiter_n: directed scenarios plus a random phase,
// all checked cycle by cycle against an ownership/pointer reference model.
module tb_wb_arbiter_n;

    localparam int NUM_M   = 4;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int SW      = DW / 8;
    localparam int TIMEOUT = 16;
`ifdef WB_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NUM_M-1:0]      cyc, stb, we;
    logic [NUM_M*AW-1:0]   adr;
    logic [NUM_M*DW-1:0]   wdat;
    logic [NUM_M*SW-1:0]   sel;
    logic [DW-1:0]         m_dat;
    logic [NUM_M-1:0]      m_ack, m_err, grant;
    logic                  s_cyc, s_stb, s_we;
    logic [AW-1:0]         s_adr;
    logic [DW-1:0]         s_dat_o, s_dat_i;
    logic [SW-1:0]         s_sel;
    logic                  s_ack, s_err;

    int checks = 0;
    int errors = 0;
    int owner, ptr, cnt;

    always #5 clk = ~clk;

    wb_arbiter_n #(
        .NUM_M(NUM_M), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)
    ) dut (
        .CLK_I(clk), .RST_I(rst),
        .M_CYC_I(cyc), .M_STB_I(stb), .M_WE_I(we),
        .M_ADR_I(adr), .M_DAT_I(wdat), .M_SEL_I(sel),
        .M_DAT_O(m_dat), .M_ACK_O(m_ack), .M_ERR_O(m_err),
        .S_CYC_O(s_cyc), .S_STB_O(s_stb), .S_WE_O(s_we),
        .S_ADR_O(s_adr), .S_DAT_O(s_dat_o), .S_SEL_O(s_sel),
        .S_DAT_I(s_dat_i), .S_ACK_I(s_ack), .S_ERR_I(s_err),
        .GRANT_O(grant)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: one owner index (-1 = idle), a last-owner pointer and a stall count.
    task automatic model_edge();
        if (rst) begin
            owner = -1;
            ptr   = NUM_M - 1;
            cnt   = 0;
        end else if (owner < 0) begin
            for (int off = 1; off <= NUM_M; off++) begin
                int k;
                k = (ptr + off) % NUM_M;
                if (cyc[k]) begin
                    owner = k;
                    cnt   = 0;
                    break;
                end
            end
        end else begin
            if (TO_EN) begin
                if (cnt == TIMEOUT || s_ack || s_err) cnt = 0;
                else if (stb[owner]) cnt++;
            end
            if (!cyc[owner]) begin
                ptr   = owner;
                owner = -1;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [NUM_M-1:0] eg, eack, eerr;
        logic             ecyc, estb, ewe, to_now;
        logic [AW-1:0]    eadr;
        logic [DW-1:0]    ewd, erd;
        logic [SW-1:0]    esel;
        #1;
        eg = '0; eack = '0; eerr = '0;
        ecyc = 1'b0; estb = 1'b0; ewe = 1'b0;
        eadr = '0; ewd = '0; erd = '0; esel = '0;
        to_now = TO_EN && (owner >= 0) && (cnt == TIMEOUT);
        if (owner >= 0) begin
            eg[owner]   = 1'b1;
            ecyc        = cyc[owner];
            estb        = stb[owner] & ~to_now;
            ewe         = we[owner];
            eadr        = adr[owner*AW +: AW];
            ewd         = wdat[owner*DW +: DW];
            esel        = sel[owner*SW +: SW];
            eack[owner] = s_ack;
            eerr[owner] = s_err | to_now;
            erd         = s_dat_i;
        end
        chk({tag, ".grant"}, 64'(grant), 64'(eg));
        chk({tag, ".s_cyc"}, 64'(s_cyc), 64'(ecyc));
        chk({tag, ".s_stb"}, 64'(s_stb), 64'(estb));
        chk({tag, ".s_we"},  64'(s_we),  64'(ewe));
        chk({tag, ".s_adr"}, 64'(s_adr), 64'(eadr));
        chk({tag, ".s_dat"}, 64'(s_dat_o), 64'(ewd));
        chk({tag, ".s_sel"}, 64'(s_sel), 64'(esel));
        chk({tag, ".m_ack"}, 64'(m_ack), 64'(eack));
        chk({tag, ".m_err"}, 64'(m_err), 64'(eerr));
        chk({tag, ".m_dat"}, 64'(m_dat), 64'(erd));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic step(input string tag);
        check_outputs(tag);
        tick();
    endtask

    task automatic set_m(input int k, input logic c, input logic s, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        cyc[k] = c; stb[k] = s; we[k] = w;
        adr[k*AW +: AW] = a;
        wdat[k*DW +: DW] = d;
        sel[k*SW +: SW] = '1;
    endtask

    function automatic int gidx(input logic [NUM_M-1:0] g);
        int r;
        r = -1;
        for (int k = 0; k < NUM_M; k++) if (g[k]) r = k;
        return r;
    endfunction

    initial begin
        int w, g, first_err, n_err;
        owner = -1; ptr = NUM_M - 1; cnt = 0;
        cyc = '0; stb = '0; we = '0; adr = '0; wdat = '0; sel = '0;
        s_dat_i = '0; s_ack = 1'b0; s_err = 1'b0; rst = 1'b1;
        tick(); tick();
        rst = 1'b0;

        // reset state, and slave ACK in IDLE must not leak through
        check_outputs("reset");
        chk("reset.grant0", 64'(grant), 64'd0);
        s_ack = 1'b1; s_dat_i = 32'h1234_5678;
        step("idle_ack");
        chk("idle_ack.m_ack0", 64'(m_ack), 64'd0);
        chk("idle_ack.m_dat0", 64'(m_dat), 64'd0);
        s_ack = 1'b0;

        // single master 1 read at 0x100, slave ACKs after 2 waits
        set_m(1, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0);
        check_outputs("t1_req");
        chk("t1_grant_pre", 64'(grant), 64'd0);
        tick();
        chk("t1_grant", 64'(grant), 64'b0010);
        step("t1_w1");
        step("t1_w2");
        s_ack = 1'b1; s_dat_i = 32'hCAFE_0100;
        check_outputs("t1_ack");
        chk("t1_ack_vec", 64'(m_ack), 64'b0010);
        chk("t1_rdata", 64'(m_dat), 64'hCAFE_0100);
        chk("t1_adr", 64'(s_adr), 64'h100);
        tick();
        s_ack = 1'b0;
        set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step("t1_rel");
        chk("t1_idle", 64'(grant), 64'd0);

        // simultaneous request right after reset: 0 first, 1 two cycles after release
        rst = 1'b1; tick(); rst = 1'b0;
        set_m(0, 1'b1, 1'b1, 1'b1, 32'h40, 32'hA0A0_A0A0);
        set_m(1, 1'b1, 1'b1, 1'b0, 32'h80, 32'h0);
        step("t2_arb");
        chk("t2_first", 64'(grant), 64'b0001);
        s_ack = 1'b1;
        step("t2_ack0");
        s_ack = 1'b0;
        set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step("t2_rel");
        chk("t2_gap", 64'(grant), 64'd0);
        step("t2_arb1");
        chk("t2_second", 64'(grant), 64'b0010);
        s_ack = 1'b1;
        step("t2_ack1");
        s_ack = 1'b0;
        set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step("t2_rel1");

        // fairness: all four request continuously, 8 transactions
        rst = 1'b1; tick(); rst = 1'b0;
        for (int k = 0; k < NUM_M; k++) set_m(k, 1'b1, 1'b1, 1'b0, 32'(k * 16), 32'h0);
        for (int t = 0; t < 8; t++) begin
            w = 0;
            while (grant == '0 && w < 8) begin
                step("fair_wait");
                w++;
            end
            chk("fair_wait_bound", 64'(w < 8), 64'd1);
            g = gidx(grant);
            chk("fair_order", 64'(g), 64'(t % NUM_M));
            if (g >= 0) begin
                s_ack = 1'b1; s_dat_i = $urandom;
                step("fair_ack");
                s_ack = 1'b0;
                cyc[g] = 1'b0; stb[g] = 1'b0;
                step("fair_rel");
                if (t < 7) begin
                    cyc[g] = 1'b1; stb[g] = 1'b1;
                end
            end
        end
        cyc = '0; stb = '0;
        step("fair_end");

        // burst hold: master 0 keeps CYC for 4 beats while master 1 waits
        set_m(0, 1'b1, 1'b1, 1'b1, 32'h200, 32'h0);
        step("t4_arb");
        chk("t4_grant", 64'(grant), 64'b0001);
        set_m(1, 1'b1, 1'b1, 1'b0, 32'h300, 32'h0);
        for (int b = 0; b < 4; b++) begin
            set_m(0, 1'b1, 1'b1, 1'b1, 32'(32'h200 + b * 4), $urandom);
            step("t4_wait");
            if (b == 2) begin
                stb[0] = 1'b0;
                check_outputs("t4_nostb");
                chk("t4_nostb_stb", 64'(s_stb), 64'd0);
                chk("t4_nostb_grant", 64'(grant), 64'b0001);
                tick();
                stb[0] = 1'b1;
            end
            s_ack = 1'b1; s_dat_i = $urandom;
            check_outputs("t4_beat");
            chk("t4_beat_grant", 64'(grant), 64'b0001);
            chk("t4_beat_ack", 64'(m_ack), 64'b0001);
            tick();
            s_ack = 1'b0;
        end
        set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step("t4_rel");
        step("t4_arb1");
        chk("t4_next", 64'(grant), 64'b0010);
        s_ack = 1'b1;
        step("t4_ack1");
        s_ack = 1'b0;
        set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step("t4_rel1");

        // reset mid-transfer; pointer now points at master 1 and must reload
        set_m(0, 1'b1, 1'b1, 1'b0, 32'h500, 32'h0);
        step("t5_arb");
        chk("t5_grant", 64'(grant), 64'b0001);
        step("t5_wait");
        rst = 1'b1; s_ack = 1'b1;
        step("t5_rst");
        chk("t5_s_cyc", 64'(s_cyc), 64'd0);
        chk("t5_grant0", 64'(grant), 64'd0);
        chk("t5_ack_drop", 64'(m_ack), 64'd0);
        rst = 1'b0; s_ack = 1'b0;
        set_m(3, 1'b1, 1'b1, 1'b0, 32'h700, 32'h0);
        step("t5_rearb");
        chk("t5_prio", 64'(grant), 64'b0001);
        cyc = '0; stb = '0;
        step("t5_rel");
        step("t5_idle");

        // hung slave on master 2
        set_m(2, 1'b1, 1'b1, 1'b0, 32'h900, 32'h0);
        step("t6_arb");
        chk("t6_grant", 64'(grant), 64'b0100);
        first_err = -1; n_err = 0;
        for (int i = 0; i < 25; i++) begin
            check_outputs("t6_stall");
            if (m_err[2]) begin
                n_err++;
                if (first_err < 0) first_err = i;
            end
            tick();
        end
        if (TO_EN) begin
            chk("t6_err_at", 64'(first_err), 64'(TIMEOUT));
            chk("t6_err_cnt", 64'(n_err), 64'd1);
        end else begin
            chk("t6_no_err", 64'(n_err), 64'd0);
        end
        cyc = '0; stb = '0;
        step("t6_rel");

        // random traffic
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < NUM_M; k++) begin
                if (cyc[k]) begin
                    if ($urandom_range(5) == 0) begin
                        cyc[k] = 1'b0; stb[k] = 1'b0;
                    end else begin
                        stb[k] = ($urandom_range(3) != 0);
                    end
                end else if ($urandom_range(3) == 0) begin
                    cyc[k] = 1'b1; stb[k] = 1'b1;
                end
                we[k] = $urandom_range(1) == 1;
                adr[k*AW +: AW] = $urandom;
                wdat[k*DW +: DW] = $urandom;
                sel[k*SW +: SW] = SW'($urandom);
            end
            s_ack   = ($urandom_range(2) == 0);
            s_err   = ($urandom_range(15) == 0);
            s_dat_i = $urandom;
            rst     = ($urandom_range(99) == 0);
            step("rand");
        end
        rst = 1'b0; s_ack = 1'b0; s_err = 1'b0;
        step("rand_end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_arbiter_n.md
Name: wb_arbiter_n

Overview:
- Parametrised Wishbone (classic, B3) arbiter. Multiplexes N bus masters onto one slave port.
- First use: merging the CPU instruction and data buses onto a single memory. Also used in the bench to add DMA/debug masters.
- Successor to the fixed two-bus hookup. Generalised in master count, address width and data width.
- Adds round-robin fairness, per-master grant visibility and an optional bus watchdog.

Parameters:
- NUM_M, 2, number of masters (2..8)
- AW, 32, address width
- DW, 32, data width (multiple of 8)
- TIMEOUT, 255, watchdog limit in cycles (used only with the optional feature)

Ports:
- CLK_I  in  1  single system clock, rising edge
- RST_I  in  1  synchronous reset, active-high
- M_CYC_I  in  NUM_M  per-master CYC
- M_STB_I  in  NUM_M  per-master STB
- M_WE_I  in  NUM_M  per-master WE
- M_ADR_I  in  NUM_M*AW  packed addresses; master k at [k*AW +: AW]
- M_DAT_I  in  NUM_M*DW  packed write data
- M_SEL_I  in  NUM_M*DW/8  packed byte selects
- M_DAT_O  out  DW  read data, broadcast to all masters
- M_ACK_O  out  NUM_M  per-master ACK
- M_ERR_O  out  NUM_M  per-master ERR
- S_CYC_O, S_STB_O, S_WE_O  out  1 each  slave control
- S_ADR_O  out  AW  slave address
- S_DAT_O  out  DW  slave write data
- S_SEL_O  out  DW/8  slave byte selects
- S_DAT_I  in  DW  slave read data
- S_ACK_I  in  1  slave ACK
- S_ERR_I  in  1  slave ERR
- GRANT_O  out  NUM_M  one-hot current owner; all zero when idle

Behaviour:
- Reset (RST_I high at a rising edge):
  - state=IDLE, GRANT_O=0, last-grant pointer=NUM_M-1, so master 0 has first priority.
  - All S_* outputs 0; M_ACK_O=0, M_ERR_O=0, M_DAT_O=0.
- FSM IDLE:
  - If any M_CYC_I is high, pick the first requester searching upward from pointer+1, modulo NUM_M.
  - Register its one-hot grant; go to BUSY.
  - Arbitration latency is exactly 1 cycle: the slave sees CYC on the cycle after the request is first seen.
- FSM BUSY:
  - S_CYC/STB/WE/ADR/DAT/SEL are combinational muxes of the granted master's inputs.
  - M_ACK_O[g]=S_ACK_I, M_ERR_O[g]=S_ERR_I, for the granted master g only. All other ACK/ERR bits are 0.
  - M_DAT_O=S_DAT_I. It is 0 in IDLE.
- Ownership:
  - Held for the whole CYC, so block transfers are never interleaved.
  - When the granted M_CYC_I falls: go to IDLE, pointer=g, GRANT_O=0 on the next edge.
  - The soonest re-grant is therefore 2 cycles after release (1 cycle in IDLE, 1 cycle of arbitration latency).
- In IDLE all S_* outputs are 0. Slave ACK/ERR arriving in IDLE is ignored and never forwarded.
- A master dropping STB while keeping CYC keeps ownership. S_STB_O follows it to 0.
- Simultaneous events:
  - Release and new requests in the same cycle: the new request is arbitrated in IDLE on the following cycle.
  - A request that arrives during BUSY waits. Masters are never starved: worst-case wait is NUM_M-1 transactions.
- RST_I asserted mid-transfer: on the next edge S_CYC_O=0, GRANT_O=0 and the pointer reloads. The in-flight ACK is dropped.
- No combinational path from S_ACK_I into the grant logic other than through the M_CYC_I release.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- Defined:
  - An 8..16-bit counter clears on grant, on S_ACK_I or on S_ERR_I.
  - It increments each BUSY cycle with S_STB_O=1 and neither ACK nor ERR.
  - When it equals TIMEOUT: M_ERR_O[g] pulses for one cycle, S_STB_O is forced 0 that cycle, and the counter clears.
  - Ownership is then released normally when the master drops CYC.
- Undefined: no counter exists. M_ERR_O is a pure pass-through of S_ERR_I, and a hung slave hangs the owner indefinitely.

Decomposition:
- Package wb_arb_pkg: the state enum (IDLE, BUSY) and the localparam for timeout counter width.
- Sub-module rr_picker (NUM_M): combinational round-robin priority encoder. Inputs are the request vector and the pointer; output is a one-hot winner. It is reused by future interrupt and DMA arbiters.

Test Plan:
- Single master: NUM_M=2, master 1 does a read at 0x100 with the slave ACKing after 2 waits -> GRANT_O=2'b10 one cycle after CYC, M_ACK_O=2'b10 once, M_DAT_O equals slave data.
- Simultaneous: both masters raise CYC in the same cycle straight after reset -> master 0 is granted first; after it releases, master 1 is granted 2 cycles later.
- Fairness: NUM_M=4, all masters request continuously, 8 transactions -> grant order 0,1,2,3,0,1,2,3.
- Burst hold: master 0 holds CYC for 4 STB/ACK beats while master 1 requests -> GRANT_O stays 0001 for all 4 beats; master 1 never sees ACK.
- Reset mid-transfer: RST_I pulsed while master 0 is BUSY -> next edge S_CYC_O=0, GRANT_O=0; after reset, master 0 has priority again.
- WB_ARB_TIMEOUT_EN with TIMEOUT=16 and a slave that never ACKs -> M_ERR_O[g] pulses exactly 16 stall cycles after STB. Without the macro, no ERR ever occurs.
